// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data-memory responder for the core's
// load/store port. It accepts one request at a time, inserts WAIT_CYCLES wait
// states, then performs the store or returns load data with a one-cycle ready
// strobe. Misaligned or out-of-range accesses are flagged with err.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-low reset
//   req        in   1   request valid, sampled only when idle
//   we         in   1   1 = store, 0 = load
//   direccion  in  32   byte address
//   palabra    in  32   store data
//   be         in   4   byte enables (only when DMEM_BYTE_WRITE_EN is defined)
//   leer_dato  out 32   load data, valid while ready is high
//   ready      out  1   one-cycle response strobe
//   err        out  1   qualifies ready: misaligned or out-of-range access
//   busy       out  1   high whenever an access is in flight
//
// Optional feature macro: DMEM_BYTE_WRITE_EN (per-byte store enables).
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] direccion,
  input  logic [31:0] palabra,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] leer_dato,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]      be_q, be_d;
`endif

  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   idx_c;
  logic            acc_err_c;
  logic            mem_we_c;

  // Word index and error decode from the latched address; any set bit above
  // the index field is out of range (no wrap-around).
  assign idx_c     = addr_q[AW+1:2];
  assign acc_err_c = (|addr_q[1:0]) | (|addr_q[31:AW+2]);

  // Next-state and response logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    mem_we_c = 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
    be_d     = be_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = direccion;
          wdata_d = palabra;
`ifdef DMEM_BYTE_WRITE_EN
          be_d    = be;
`endif
          cnt_d   = CW'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          ready_d = 1'b1;
          state_d = S_RESP;
          if (acc_err_c) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (we_q) begin
            mem_we_c = 1'b1;
          end else begin
            rdata_d = mem_q[idx_c];
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef DMEM_BYTE_WRITE_EN
      be_q    <= be_d;
`endif
    end
  end

  // Storage array; contents survive reset. A store only commits on the
  // WAIT->RESP edge, so reset earlier in the access drops it.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
`ifdef DMEM_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
`else
      mem_q[idx_c] <= wdata_q;
`endif
    end
  end

  assign leer_dato = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a driver issues accesses and
// pushes the expected response computed by a word-array reference model; a
// negedge monitor pops and compares whenever ready is high.
module tb_data_mem_responder;

  localparam int unsigned DEPTH       = 256;
  localparam int unsigned WAIT_CYCLES = 2;
`ifdef DMEM_BYTE_WRITE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] direccion = '0;
  logic [31:0] palabra   = '0;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  be = 4'hF;
`endif
  logic [31:0] leer_dato;
  logic        ready, err, busy;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .direccion(direccion), .palabra(palabra),
`ifdef DMEM_BYTE_WRITE_EN
    .be(be),
`endif
    .leer_dato(leer_dato), .ready(ready), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  // Reference model: word array plus the last value presented on leer_dato.
  logic [31:0] mdl_mem [int];
  logic [31:0] mdl_rdata = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Applies one access to the model; returns the response the DUT owes.
  function automatic exp_t model(bit w, logic [31:0] a, logic [31:0] d,
                                 logic [3:0] m, int due);
    exp_t        e;
    int          idx;
    logic [31:0] cur;
    logic [3:0]  mask;
    e.cyc = due;
    e.err = 1'b0;
    idx   = int'(a >> 2);
    mask  = BYTE_EN ? m : 4'hF;
    if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) begin
      e.err     = 1'b1;
      mdl_rdata = '0;
    end else if (w) begin
      cur = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (mask[b]) cur[8*b +: 8] = d[8*b +: 8];
      mdl_mem[idx] = cur;
    end else begin
      mdl_rdata = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
    end
    e.rdata = mdl_rdata;
    return e;
  endfunction

  // Monitor: compare every response against the scoreboard head.
  always @(negedge clk) begin
    if (rst && ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=1 required=0 at t=%0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("leer_dato", leer_dato, e.rdata);
        chk("err", 32'(err), 32'(e.err));
        chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_in_resp", 32'(busy), 32'd1);
      end
    end else if (err) begin
      checks++;
      errors++;
      $display("FAIL err_without_ready actual=1 required=0 at t=%0t", $time);
    end
  end

  // Waits (bounded) for the responder to be idle; returns at a negedge.
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle at t=%0t", $time);
    end
  endtask

  // mode: 0 = not modelled, 1 = modelled and expected, 2 = modelled only.
  task automatic issue(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                       int mode);
    exp_t e;
    wait_idle();
    req = 1'b1; we = w; direccion = a; palabra = d;
`ifdef DMEM_BYTE_WRITE_EN
    be = m;
`endif
    @(posedge clk); #1;
    if (mode != 0) begin
      e = model(w, a, d, m, cyc + 1 + int'(WAIT_CYCLES));
      if (mode == 1) sbq.push_back(e);
    end
    // Garbage on the inputs must not disturb the access in flight.
    req = 1'b0; we = 1'($urandom); direccion = $urandom; palabra = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    case ($urandom_range(0, 9))
      0: a = a | 32'($urandom_range(1, 3));
      1: a = a + 32'(DEPTH * 4);
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("rst_leer_dato", leer_dato, 32'h0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Initialise words 0..15 and the last valid word
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1);
    issue(1'b1, 32'((DEPTH - 1) * 4), 32'hCAFE0001, 4'hF, 1);
    issue(1'b0, 32'((DEPTH - 1) * 4), 32'h0, 4'hF, 1);

    // Basic store/load
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1);

    // Error cases, then the word must be untouched
    issue(1'b0, 32'h13, 32'h0, 4'hF, 1);
    issue(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 1);
    issue(1'b1, 32'h80000010, 32'h12345678, 4'hF, 1);
    issue(1'b1, 32'h12, 32'h12345678, 4'hF, 1);
    issue(1'b0, 32'h10, 32'h0, 4'hF, 1);
    issue(1'b1, 32'h14, 32'h0BADF00D, 4'hF, 1);
    issue(1'b0, 32'h80000010, 32'h0, 4'hF, 1);

    // Reset during WAIT drops the store
    issue(1'b1, 32'h20, 32'h11111111, 4'hF, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_leer_dato", leer_dato, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mdl_rdata = '0;
    issue(1'b0, 32'h20, 32'h0, 4'hF, 1);

    // Reset during RESP: ready drops at once, store already committed
    issue(1'b1, 32'h24, 32'h5A5AA5A5, 4'hF, 2);
    repeat (WAIT_CYCLES + 1) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("resp_rst_ready", 32'(ready), 32'd0);
    chk("resp_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mdl_rdata = '0;
    issue(1'b0, 32'h24, 32'h0, 4'hF, 1);

    // req held high with inputs toggling every cycle
    wait_idle();
    for (int k = 0; k < 5 * 6; k++) begin
      req = 1'b1; we = 1'($urandom); direccion = rand_addr(); palabra = $urandom;
`ifdef DMEM_BYTE_WRITE_EN
      be = 4'($urandom);
`endif
      if (k % (WAIT_CYCLES + 3) == 0) begin
`ifdef DMEM_BYTE_WRITE_EN
        sbq.push_back(model(we, direccion, palabra, be, cyc + 2 + int'(WAIT_CYCLES)));
`else
        sbq.push_back(model(we, direccion, palabra, 4'hF, cyc + 2 + int'(WAIT_CYCLES)));
`endif
      end
      @(negedge clk);
    end
    req = 1'b0;

`ifdef DMEM_BYTE_WRITE_EN
    // Byte enables
    issue(1'b1, 32'h0, 32'h0, 4'hF, 1);
    issue(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 1);
    issue(1'b0, 32'h0, 32'h0, 4'hF, 1);
    issue(1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, 1);
    issue(1'b0, 32'h0, 32'h0, 4'b0000, 1);
`endif

    // Random traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), rand_addr(), $urandom, 4'($urandom), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Drain the scoreboard
    begin
      int n = 0;
      while (sbq.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (sbq.size() != 0) begin
        errors++;
        $display("FAIL drain actual=%0d required=0 pending", sbq.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
